// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit beside the D stage: writer scoreboard, forward selects, mult/div busy tracking.
// Optional HAZ_PERF_CNT_EN adds stall_cnt / md_stall_cnt performance counters.
module hazard_scoreboard #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned AW       = 5,
  parameter int unsigned TW       = 5,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned SELW     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_re_rs,
  input  logic            d_re_rt,
  input  logic [AW-1:0]   d_rs,
  input  logic [AW-1:0]   d_rt,
  input  logic [TW-1:0]   d_tuse_rs,
  input  logic [TW-1:0]   d_tuse_rt,
  input  logic            d_wr,
  input  logic [AW-1:0]   d_wa,
  input  logic [TW-1:0]   d_tnew,
  input  logic            d_md_start,
  input  logic            d_md_div,
  input  logic            d_hilo_use,
  output logic            stall,
  output logic            e_bubble,
  output logic [SELW-1:0] fwd_rs,
  output logic            fwd_rs_rdy,
  output logic [SELW-1:0] fwd_rt,
  output logic            fwd_rt_rdy,
  output logic            md_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     md_stall_cnt
`endif
);

  localparam int unsigned MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW     = $clog2(MD_MAX + 1);

  logic [STAGES:1] valid_q, valid_d;
  logic [AW-1:0]   wa_q   [1:STAGES];
  logic [AW-1:0]   wa_d   [1:STAGES];
  logic [TW-1:0]   tnew_q [1:STAGES];
  logic [TW-1:0]   tnew_d [1:STAGES];
  logic            md_q, md_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            rs_hit, rt_hit, data_stall, md_stall;
  logic [TW-1:0]   rs_tnew, rt_tnew;

  // Scan far-to-near so the nearest matching stage overwrites farther ones.
  always_comb begin
    fwd_rs     = '0;
    fwd_rs_rdy = 1'b0;
    fwd_rt     = '0;
    fwd_rt_rdy = 1'b0;
    rs_hit     = 1'b0;
    rt_hit     = 1'b0;
    rs_tnew    = '0;
    rt_tnew    = '0;
    for (int unsigned k = STAGES; k >= 1; k--) begin
      if (valid_q[k] && wa_q[k] == d_rs && d_rs != '0 && d_re_rs) begin
        fwd_rs     = SELW'(k);
        fwd_rs_rdy = (tnew_q[k] == '0);
        rs_hit     = 1'b1;
        rs_tnew    = tnew_q[k];
      end
      if (valid_q[k] && wa_q[k] == d_rt && d_rt != '0 && d_re_rt) begin
        fwd_rt     = SELW'(k);
        fwd_rt_rdy = (tnew_q[k] == '0);
        rt_hit     = 1'b1;
        rt_tnew    = tnew_q[k];
      end
    end
    md_busy    = (cnt_q != '0);
    data_stall = (rs_hit && rs_tnew > d_tuse_rs) || (rt_hit && rt_tnew > d_tuse_rt);
    md_stall   = d_hilo_use && (md_busy || md_q);
    stall      = data_stall || md_stall;
    e_bubble   = stall;
  end

  always_comb begin
    valid_d   = '0;
    wa_d      = wa_q;
    tnew_d    = tnew_q;
    valid_d[1] = !stall && d_wr && d_wa != '0;
    wa_d[1]    = d_wa;
    tnew_d[1]  = stall ? '0 : d_tnew;
    md_d       = d_md_start && !stall;
    for (int unsigned k = 2; k <= STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      wa_d[k]    = wa_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
    end
    // A new issue reloads the counter even on the edge it would have reached zero.
    if (d_md_start && !stall) begin
      cnt_d = d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      md_q    <= 1'b0;
      cnt_q   <= '0;
      for (int unsigned k = 1; k <= STAGES; k++) begin
        wa_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      md_q    <= md_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      tnew_q  <= tnew_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    md_stall_cnt_d = md_stall ? md_stall_cnt_q + 32'd1 : md_stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule
